// File: rtl/shiftreg_rw_if.sv
// Bus between the configuration shift-register engine and its user/chip pins.
// The master side drives the request and the chip's serial return; the slave is the engine.
interface shiftreg_rw_if #(
    parameter int unsigned DATA_WIDTH = 170,
    parameter int unsigned DIV_WIDTH  = 8
);
    logic                  start;
    logic [DIV_WIDTH-1:0]  clk_div;
    logic [DATA_WIDTH-1:0] data_wr;
    logic                  sr_dout;
    logic                  sr_clk;
    logic                  sr_din;
    logic                  sr_load;
    logic                  busy;
    logic                  valid;
    logic [DATA_WIDTH-1:0] data_rd;

    modport master (
        output start, clk_div, data_wr, sr_dout,
        input  sr_clk, sr_din, sr_load, busy, valid, data_rd
    );

    modport slave (
        input  start, clk_div, data_wr, sr_dout,
        output sr_clk, sr_din, sr_load, busy, valid, data_rd
    );
endinterface

// File: rtl/shiftreg_rw_engine.sv
// Serial read/write engine: shifts a word MSB-first into the chip while capturing
// the returned bits, strobes the chip latch, then presents the readback word.
module shiftreg_rw_engine #(
    parameter int unsigned DATA_WIDTH = 170,
    parameter int unsigned DIV_WIDTH  = 8,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic            clk,
    input  logic            rst,
    shiftreg_rw_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        DONE
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] sreg;
    logic [CNT_WIDTH-1:0]  bit_cnt;
    logic [DIV_WIDTH-1:0]  div_cnt;
    logic [DIV_WIDTH-1:0]  half_m1;
    logic                  phase_end;

    // Outputs are registered from the next-state decision so they line up with the state.
    assign phase_end = (div_cnt == half_m1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            sreg         <= '0;
            bit_cnt      <= '0;
            div_cnt      <= '0;
            half_m1      <= '0;
            bus.sr_clk   <= 1'b0;
            bus.sr_din   <= 1'b0;
            bus.sr_load  <= 1'b0;
            bus.busy     <= 1'b0;
            bus.valid    <= 1'b0;
            bus.data_rd  <= '0;
        end else begin
            bus.valid <= 1'b0;
            case (state)
                IDLE: begin
                    bus.sr_clk  <= 1'b0;
                    bus.sr_din  <= 1'b0;
                    bus.sr_load <= 1'b0;
                    bus.busy    <= 1'b0;
                    if (bus.start) begin
                        sreg       <= bus.data_wr;
                        half_m1    <= bus.clk_div;
                        bit_cnt    <= CNT_WIDTH'(DATA_WIDTH);
                        div_cnt    <= '0;
                        bus.busy   <= 1'b1;
                        bus.sr_din <= bus.data_wr[DATA_WIDTH-1];
                        state      <= SHIFT_LO;
                    end
                end

                // Capture the chip's bit at the end of the low phase, just before sr_clk rises.
                SHIFT_LO: begin
                    if (phase_end) begin
                        div_cnt    <= '0;
                        sreg       <= {sreg[DATA_WIDTH-2:0], bus.sr_dout};
                        bus.sr_clk <= 1'b1;
                        state      <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + DIV_WIDTH'(1);
                    end
                end

                SHIFT_HI: begin
                    if (phase_end) begin
                        div_cnt    <= '0;
                        bit_cnt    <= bit_cnt - CNT_WIDTH'(1);
                        bus.sr_clk <= 1'b0;
                        if (bit_cnt == CNT_WIDTH'(1)) begin
                            bus.sr_load <= 1'b1;
                            state       <= LOAD;
                        end else begin
                            bus.sr_din <= sreg[DATA_WIDTH-1];
                            state      <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_WIDTH'(1);
                    end
                end

                LOAD: begin
                    if (phase_end) begin
                        div_cnt     <= '0;
                        bus.sr_load <= 1'b0;
                        bus.valid   <= 1'b1;
                        bus.data_rd <= sreg;
                        state       <= DONE;
                    end else begin
                        div_cnt <= div_cnt + DIV_WIDTH'(1);
                    end
                end

                DONE: begin
                    bus.busy   <= 1'b0;
                    bus.sr_din <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shiftreg_rw_engine.sv
// Directed + randomized bench for shiftreg_rw_engine using a shift-register chip model.
module tb_shiftreg_rw_engine;

    localparam int unsigned WS = 8;
    localparam int unsigned WB = 170;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    shiftreg_rw_if #(.DATA_WIDTH(WS), .DIV_WIDTH(DW)) s_if ();
    shiftreg_rw_if #(.DATA_WIDTH(WB), .DIV_WIDTH(DW)) b_if ();

    shiftreg_rw_engine #(.DATA_WIDTH(WS), .DIV_WIDTH(DW), .CNT_WIDTH(8)) u_small (
        .clk (clk),
        .rst (rst),
        .bus (s_if.slave)
    );

    shiftreg_rw_engine #(.DATA_WIDTH(WB), .DIV_WIDTH(DW), .CNT_WIDTH(8)) u_big (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    // Chip models: a shift register that moves one bit in on every sr_clk rising edge.
    logic [WS-1:0] chip_s = '0;
    logic [WS-1:0] pre_s  = '0;
    logic          ld_s   = 1'b0;
    logic          clkq_s = 1'b0;
    logic [WB-1:0] chip_b = '0;
    logic [WB-1:0] pre_b  = '0;
    logic          ld_b   = 1'b0;
    logic          clkq_b = 1'b0;
    logic          tie_b  = 1'b0;
    logic          tie_v  = 1'b0;

    always @(posedge clk) begin
        if (ld_s) chip_s <= pre_s;
        else if (s_if.sr_clk && !clkq_s) chip_s <= {chip_s[WS-2:0], s_if.sr_din};
        clkq_s <= s_if.sr_clk;
        if (ld_b) chip_b <= pre_b;
        else if (b_if.sr_clk && !clkq_b) chip_b <= {chip_b[WB-2:0], b_if.sr_din};
        clkq_b <= b_if.sr_clk;
    end

    assign s_if.sr_dout = chip_s[WS-1];
    assign b_if.sr_dout = tie_b ? tie_v : chip_b[WB-1];

    function automatic logic [WB-1:0] rand_wide();
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[WB-1:0];
    endfunction

    task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One transaction on the 8-bit engine; optional extra start pulse at cycle restart_at.
    task automatic small_txn(input logic [WS-1:0] wr, input logic [WS-1:0] pre,
                             input int div, input int restart_at, input string tag);
        int h, lat, rises, vcnt, vcyc, loads, hi_cyc;
        logic prev, busy1, busy_after;
        logic [WS-1:0] sent, rd;
        h = div + 1;
        lat = 2 * h * WS + h + 1;
        pre_s = pre; ld_s = 1'b1;
        @(negedge clk);
        ld_s = 1'b0;
        s_if.data_wr = wr; s_if.clk_div = DW'(div); s_if.start = 1'b1;
        prev = 1'b0; rises = 0; vcnt = 0; vcyc = -1; loads = 0; hi_cyc = 0;
        sent = '0; rd = '0; busy1 = 1'b0; busy_after = 1'b1;
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            s_if.start   = (k == restart_at);
            s_if.data_wr = WS'($urandom);
            s_if.clk_div = DW'($urandom);
            if (k == 1) busy1 = s_if.busy;
            if (k == lat + 1) busy_after = s_if.busy;
            if (s_if.sr_clk && !prev) begin
                sent = {sent[WS-2:0], s_if.sr_din};
                rises++;
            end
            prev = s_if.sr_clk;
            if (s_if.sr_clk) hi_cyc++;
            if (s_if.sr_load) loads++;
            if (s_if.valid) begin vcnt++; vcyc = k; rd = s_if.data_rd; end
        end
        s_if.start = 1'b0;
        chk({tag, "_busy_c1"}, WB'(busy1), WB'(1'b1));
        chk_int({tag, "_rises"}, rises, WS);
        chk({tag, "_din_seq"}, WB'(sent), WB'(wr));
        chk_int({tag, "_hi_cycles"}, hi_cyc, WS * h);
        chk_int({tag, "_load_cycles"}, loads, h);
        chk_int({tag, "_valid_count"}, vcnt, 1);
        chk_int({tag, "_valid_cycle"}, vcyc, lat);
        chk({tag, "_data_rd"}, WB'(rd), WB'(pre));
        chk({tag, "_busy_after"}, WB'(busy_after), WB'(1'b0));
        chk({tag, "_chip_got"}, WB'(chip_s), WB'(wr));
        chk({tag, "_data_rd_held"}, WB'(s_if.data_rd), WB'(pre));
    endtask

    // One transaction on the 170-bit engine; tie=1 forces sr_dout high.
    task automatic big_txn(input logic [WB-1:0] wr, input logic [WB-1:0] pre,
                           input int div, input logic tie, input string tag);
        int h, lat, rises, vcnt, vcyc, loads, load_first, hi_bad, lo_bad, run;
        logic prev, busy1, busy_after;
        logic [WB-1:0] sent, rd, exp_rd;
        h = div + 1;
        lat = 2 * h * WB + h + 1;
        pre_b = pre; ld_b = 1'b1; tie_b = tie; tie_v = 1'b1;
        @(negedge clk);
        ld_b = 1'b0;
        b_if.data_wr = wr; b_if.clk_div = DW'(div); b_if.start = 1'b1;
        prev = 1'b0; run = 0; rises = 0; vcnt = 0; vcyc = -1; loads = 0; load_first = -1;
        hi_bad = 0; lo_bad = 0; sent = '0; rd = '0; busy1 = 1'b0; busy_after = 1'b1;
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            b_if.start   = 1'b0;
            b_if.data_wr = rand_wide();
            b_if.clk_div = DW'($urandom);
            if (k == 1) busy1 = b_if.busy;
            if (k == lat + 1) busy_after = b_if.busy;
            if (b_if.sr_clk != prev) begin
                if (prev) begin
                    if (run != h) hi_bad++;
                end else begin
                    if (run != h) lo_bad++;
                    sent = {sent[WB-2:0], b_if.sr_din};
                    rises++;
                end
                run = 0;
            end
            run++;
            prev = b_if.sr_clk;
            if (b_if.sr_load) begin
                loads++;
                if (load_first < 0) load_first = k;
            end
            if (b_if.valid) begin vcnt++; vcyc = k; rd = b_if.data_rd; end
        end
        exp_rd = tie ? {WB{1'b1}} : pre;
        chk({tag, "_busy_c1"}, WB'(busy1), WB'(1'b1));
        chk_int({tag, "_rises"}, rises, WB);
        chk_int({tag, "_hi_phase_bad"}, hi_bad, 0);
        chk_int({tag, "_lo_phase_bad"}, lo_bad, 0);
        chk({tag, "_din_seq"}, sent, wr);
        chk_int({tag, "_load_cycles"}, loads, h);
        chk_int({tag, "_load_first"}, load_first, 2 * h * WB + 1);
        chk_int({tag, "_valid_count"}, vcnt, 1);
        chk_int({tag, "_valid_cycle"}, vcyc, lat);
        chk({tag, "_data_rd"}, rd, exp_rd);
        chk({tag, "_busy_after"}, WB'(busy_after), WB'(1'b0));
        chk({tag, "_chip_got"}, chip_b, wr);
    endtask

    int act;
    int vcnt;
    int rises;
    int changed;
    int vq[$];
    logic prev;
    logic hit;
    logic busy_gap;
    logic busy_back;
    logic [WB-1:0] held;

    initial begin
        s_if.start = 1'b0; s_if.clk_div = '0; s_if.data_wr = '0;
        b_if.start = 1'b0; b_if.clk_div = '0; b_if.data_wr = '0;

        // Reset with random inputs, then idle with start low.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_if.start = 1'($urandom); s_if.clk_div = DW'($urandom); s_if.data_wr = WS'($urandom);
            b_if.start = 1'($urandom); b_if.clk_div = DW'($urandom); b_if.data_wr = rand_wide();
        end
        chk("rst_small_outs",
            WB'({s_if.sr_clk, s_if.sr_din, s_if.sr_load, s_if.busy, s_if.valid, s_if.data_rd}), '0);
        chk("rst_big_ctrl", WB'({b_if.sr_clk, b_if.sr_din, b_if.sr_load, b_if.busy, b_if.valid}), '0);
        chk("rst_big_data", b_if.data_rd, '0);
        s_if.start = 1'b0; b_if.start = 1'b0; rst = 1'b1;
        act = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (s_if.sr_clk || s_if.sr_load || s_if.busy || s_if.valid || s_if.data_rd != '0) act++;
            if (b_if.sr_clk || b_if.sr_load || b_if.busy || b_if.valid || b_if.data_rd != '0) act++;
        end
        chk_int("idle_quiet", act, 0);

        // Loopback with the chip preloaded to return the written pattern.
        small_txn(8'hA5, 8'hA5, 0, 0, "loop_a5");
        for (int i = 0; i < 4; i++)
            small_txn(WS'($urandom), WS'($urandom), int'($urandom_range(0, 3)), 0, "loop_rand");

        // Extra start pulse while busy must be ignored.
        small_txn(WS'($urandom), WS'($urandom), 0, 5, "busy_ignore");

        // start held high: back-to-back transactions, one idle cycle between.
        pre_s = 8'h96; ld_s = 1'b1;
        @(negedge clk);
        ld_s = 1'b0;
        s_if.data_wr = 8'h3C; s_if.clk_div = '0; s_if.start = 1'b1;
        vq.delete(); busy_gap = 1'b1; busy_back = 1'b0; held = '0;
        for (int k = 1; k <= 2 * 18 + 3; k++) begin
            @(negedge clk);
            if (k == 2 * 18 + 2) s_if.start = 1'b0;
            if (k == 19) busy_gap = s_if.busy;
            if (k == 20) busy_back = s_if.busy;
            if (s_if.valid) begin
                vq.push_back(k);
                held = WB'(s_if.data_rd);
            end
        end
        chk_int("held_valid_count", vq.size(), 2);
        if (vq.size() == 2) begin
            chk_int("held_valid1_cycle", vq[0], 18);
            chk_int("held_valid2_cycle", vq[1], 37);
        end
        chk("held_busy_gap", WB'(busy_gap), WB'(1'b0));
        chk("held_busy_back", WB'(busy_back), WB'(1'b1));
        chk("held_second_rd", held, WB'(8'h3C));

        // Divider H=4 with sr_dout tied high.
        big_txn(rand_wide(), rand_wide(), 3, 1'b1, "div4");

        // data_rd must hold while inputs wiggle with start low.
        changed = 0; vcnt = 0; tie_b = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            tie_v = 1'($urandom);
            b_if.data_wr = rand_wide();
            if (b_if.data_rd !== {WB{1'b1}}) changed++;
            if (b_if.valid) vcnt++;
        end
        chk_int("stable_data_rd", changed, 0);
        chk_int("stable_no_valid", vcnt, 0);

        // Reset in the middle of bit 50.
        tie_b = 1'b0;
        pre_b = rand_wide(); ld_b = 1'b1;
        @(negedge clk);
        ld_b = 1'b0;
        b_if.data_wr = rand_wide(); b_if.clk_div = '0; b_if.start = 1'b1;
        rises = 0; prev = 1'b0; hit = 1'b0;
        for (int k = 1; k <= 400 && !hit; k++) begin
            @(negedge clk);
            b_if.start = 1'b0;
            if (b_if.sr_clk && !prev) rises++;
            prev = b_if.sr_clk;
            if (rises == 51) begin
                rst = 1'b0;
                hit = 1'b1;
            end
        end
        chk("mid_rst_reached", WB'(hit), WB'(1'b1));
        @(negedge clk);
        chk("mid_rst_ctrl", WB'({b_if.sr_clk, b_if.sr_din, b_if.sr_load, b_if.busy, b_if.valid}), '0);
        chk("mid_rst_data", b_if.data_rd, '0);
        rst = 1'b1;
        vcnt = 0; act = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (b_if.valid) vcnt++;
            if (b_if.busy || b_if.sr_clk || b_if.sr_load) act++;
        end
        chk_int("mid_rst_no_valid", vcnt, 0);
        chk_int("mid_rst_quiet", act, 0);

        // Fresh transaction after the abort completes normally.
        big_txn(rand_wide(), rand_wide(), 1, 1'b0, "fresh");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
